bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble) feeding the
//  per-digit 7-segment decoders of the binary-to-decimal adder display path.
//  Accepts an unsigned sum on a start/done handshake and presents one 4-bit BCD
//  nibble per decimal digit, held stable until the next conversion completes.
// PARAMETERS
//  BIN_W   8  width of unsigned binary input (>=1)
//  DIGITS  3  number of BCD output digits (>=1); bcd width = 4*DIGITS
// PORTS
//  clk      in   1         system clock, rising edge
//  rst_n    in   1         asynchronous active-low reset
//  start    in   1         request; sampled only in IDLE
//  bin      in   BIN_W     unsigned value, captured on accepted start
//  busy     out  1         1 while a conversion is in progress (SHIFT state)
//  done     out  1         one-cycle pulse: bcd/ovf/blank_n updated this cycle
//  bcd      out  4*DIGITS  digit k at bcd[4k+3:4k], k=0 units; each 0..9
//  ovf      out  1         1 = value >= 10**DIGITS (bcd holds value mod 10**DIGITS)
//  blank_n  out  DIGITS    per-digit display enable, 1 = show digit
// BEHAVIOUR
//  - Clock: one domain, clk. Reset: rst_n, asynchronous assert, active-low.
//  - Reset: state=IDLE, busy=0, done=0, bcd=0, ovf=0, blank_n=all 1s; internal
//    shift/count registers cleared. Reset mid-conversion aborts; no done pulse.
//  - FSM: IDLE -> SHIFT on start=1 (bin captured into shift reg, work reg=0,
//    cnt=0). SHIFT: each cycle, every work digit >=5 gets +3, then
//    {work,shift} shifts left 1; cnt++; after BIN_W SHIFT cycles -> DONE.
//    DONE: output regs loaded from work reg, done=1 for this cycle -> IDLE.
//  - Latency: start sampled at edge N -> done=1 in cycle after edge N+BIN_W+1;
//    busy=1 exactly BIN_W cycles. Min start-to-start spacing BIN_W+2 cycles.
//  - start while busy or in DONE: ignored, not queued; bin changes ignored.
//  - Outputs bcd/ovf/blank_n change only in the DONE cycle; stable otherwise.
//  - ovf: sticky across the conversion; set if any 1 bit is shifted out of the
//    top digit; cleared at start acceptance, published in DONE.
//  - Arithmetic: add-3 is 4-bit, never exceeds 4'd12 before shift; no wrap.
//  - bin=0 -> bcd=0, ovf=0. Max bin (2**BIN_W-1) must convert correctly when
//    DIGITS >= ceil(BIN_W*log10(2)); otherwise ovf reports truncation.
// CONFIGURATION
//  - LEADING_ZERO_BLANK_EN defined: in DONE, blank_n[k]=0 for each digit k>0
//    whose value and all higher digits are 0 and ovf=0; digit 0 always shown
//    (value 0 displays "0"). Undefined: blank_n tied all 1s at all times.
//  - Port list identical in both builds.
// TESTING
//  1 BIN_W=8,DIGITS=3: start, bin=8'd255 -> busy 8 cycles, done pulse 9
//    cycles after start, bcd=12'h255, ovf=0.
//  2 bin=8'd0 -> bcd=12'h000, ovf=0; with LEADING_ZERO_BLANK_EN blank_n=3'b001,
//    without 3'b111. bin=8'd7 -> bcd=12'h007, same blank_n values.
//  3 start bin=8'd99, pulse start bin=8'd1 during busy -> single done,
//    bcd=12'h099; start in DONE cycle also ignored.
//  4 start bin=8'd200, deassert rst_n at 4th SHIFT cycle -> all outputs reset
//    immediately, no done; release, start bin=8'd42 -> bcd=12'h042.
//  5 DIGITS=2: bin=8'd200 -> bcd=8'h00, ovf=1; bin=8'd99 -> bcd=8'h99, ovf=0.
//  6 Sweep bin 0..255 back-to-back (start held 1) -> each bcd matches decimal
//    value, done spacing exactly BIN_W+2 cycles.

Source files
------------

// File: rtl/bin2bcd_if.sv
// -----------------------------------------------------------------------------
// bin2bcd_if
// Start/done handshake bundle between a requester and the bin2bcd_seq
// sequential binary-to-BCD converter.
//   start    requester -> converter  request, sampled only while idle
//   bin      requester -> converter  unsigned value, captured on accepted start
//   busy     converter -> requester  high while shift/add-3 iterations run
//   done     converter -> requester  one-cycle pulse, result just published
//   bcd      converter -> requester  DIGITS packed BCD nibbles, units in [3:0]
//   ovf      converter -> requester  value did not fit in DIGITS decimal digits
//   blank_n  converter -> requester  per-digit display enable, 1 = show
// Modports: master = requester side, slave = converter side.
// -----------------------------------------------------------------------------
interface bin2bcd_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
  logic [DIGITS-1:0]     blank_n;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf, blank_n
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf, blank_n
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble). One input
// bit is consumed per SHIFT cycle; after BIN_W iterations the work register is
// published on bcd/ovf/blank_n together with a one-cycle done pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, aborts any conversion in flight
//   bus    bin2bcd_if.slave: start/bin in; busy/done/bcd/ovf/blank_n out
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (k>0) are blanked in the published result
//   undefined -> blank_n is constant all ones
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  bin2bcd_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_shift;
  logic [W-1:0]       r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_acc;
  logic [W-1:0]       r_bcd;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;
  logic [W-1:0]       w_adj;

  // Correct every BCD digit >= 5 by +3 so the following doubling carries
  // into the next digit; a 4-bit digit never exceeds 12 here.
  function automatic logic [W-1:0] add3_all(input logic [W-1:0] w);
    logic [W-1:0] res;
    res = w;
    for (int k = 0; k < DIGITS; k++) begin
      if (w[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = w[4*k +: 4] + 4'd3;
      end else begin
        res[4*k +: 4] = w[4*k +: 4];
      end
    end
    return res;
  endfunction

  // Adjusted work register used by the current SHIFT iteration
  always_comb begin
    w_adj = add3_all(r_work);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_W'(BIN_W - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Conversion datapath and published result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_work    <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // busy mirrors the upcoming state so it is high for exactly BIN_W cycles
      r_busy <= (w_state_nxt == ST_SHIFT);
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.bin;
            r_work    <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // {work,shift} <<= 1 after correction; the bit leaving the top
          // digit is a lost decimal carry and makes the overflow sticky
          r_work    <= {w_adj[W-2:0], r_shift[BIN_W-1]};
          r_shift   <= r_shift << 1;
          r_ovf_acc <= r_ovf_acc | w_adj[W-1];
          r_cnt     <= r_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          r_bcd <= r_work;
          r_ovf <= r_ovf_acc;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank_n;
  logic [DIGITS-1:0] w_blank_n;

  // Digit k>0 is blanked when it and every higher digit are zero, unless the
  // value overflowed; the units digit is always shown
  always_comb begin
    logic hi_zero;
    hi_zero   = 1'b1;
    w_blank_n = '1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero      = hi_zero & (r_work[4*k +: 4] == 4'd0);
      w_blank_n[k] = ~hi_zero | r_ovf_acc;
    end
  end

  // Blanking mask is published together with bcd in the DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank_n <= '1;
    end else if (r_state == ST_DONE) begin
      r_blank_n <= w_blank_n;
    end else begin
      r_blank_n <= r_blank_n;
    end
  end

  assign bus.blank_n = r_blank_n;
`else
  assign bus.blank_n = {DIGITS{1'b1}};
`endif

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;
  assign bus.ovf  = r_ovf;

endmodule
